// File: rtl/iter_alu_if.sv
// Execute-stage ALU bus: issue fields travel from the pipeline to the ALU,
// and the result/handshake fields come back to the pipeline and the hazard unit.
interface iter_alu_if #(
   parameter int XLEN = 32
);
   logic            start_i;
   logic [3:0]      ALUCtrl_i;
   logic [XLEN-1:0] data1_i;
   logic [XLEN-1:0] data2_i;
   logic [XLEN-1:0] data_o;
   logic            zero_o;
   logic            busy_o;
   logic            done_o;

   modport master (
      output start_i, ALUCtrl_i, data1_i, data2_i,
      input  data_o, zero_o, busy_o, done_o
   );

   modport slave (
      input  start_i, ALUCtrl_i, data1_i, data2_i,
      output data_o, zero_o, busy_o, done_o
   );
endinterface

// File: rtl/iter_alu.sv
// Execute-stage ALU: AND/OR/ADD/SUB finish in one cycle, MUL iterates on a
// radix-2 shift-add engine and holds the pipeline via busy_o.
module iter_alu #(
   parameter int XLEN       = 32,
   parameter bit EARLY_EXIT = 1'b0
) (
   input logic       clk_i,
   input logic       rst_i,
   iter_alu_if.slave bus
);

   localparam int CW = $clog2(XLEN) + 1;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_MUL = 4'b0111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state, state_next;
   logic [XLEN-1:0] mcand, mplier, acc;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] data_q;
   logic            zero_q;

   logic            accept;
   logic            is_mul;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] acc_next;
   logic [XLEN-1:0] mplier_next;
   logic            mul_last;

   // Single-cycle datapath; unknown codes deliberately produce zero.
   always_comb begin
      alu_res = '0;
      unique case (bus.ALUCtrl_i)
         OP_AND:  alu_res = bus.data1_i & bus.data2_i;
         OP_OR:   alu_res = bus.data1_i | bus.data2_i;
         OP_ADD:  alu_res = bus.data1_i + bus.data2_i;
         OP_SUB:  alu_res = bus.data1_i - bus.data2_i;
         default: alu_res = '0;
      endcase
   end

   assign accept      = bus.start_i && (state != S_MUL);
   assign is_mul      = (bus.ALUCtrl_i == OP_MUL);
   assign acc_next    = acc + (mplier[0] ? mcand : '0);
   assign mplier_next = mplier >> 1;
   // Early exit only looks at the shifted multiplier, so one iteration always runs.
   assign mul_last    = (cnt == CW'(XLEN - 1)) ||
                        (EARLY_EXIT && (mplier_next == '0));

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (bus.start_i) state_next = is_mul ? S_MUL : S_DONE;
            else             state_next = S_IDLE;
         end
         S_MUL: begin
            if (mul_last) state_next = S_DONE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= S_IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         data_q <= '0;
         zero_q <= 1'b1;
      end else begin
         state <= state_next;
         if (accept) begin
            if (is_mul) begin
               mcand  <= bus.data1_i;
               mplier <= bus.data2_i;
               acc    <= '0;
               cnt    <= '0;
            end else begin
               data_q <= alu_res;
               zero_q <= (alu_res == '0);
            end
         end
         if (state == S_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier_next;
            cnt    <= cnt + 1'b1;
            if (mul_last) begin
               data_q <= acc_next;
               zero_q <= (acc_next == '0);
            end
         end
      end
   end

   assign bus.data_o = data_q;
   assign bus.zero_o = zero_q;
   assign bus.busy_o = (state == S_MUL);
   assign bus.done_o = (state == S_DONE);

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: one instance without and one with early exit,
// driven on the falling edge and checked on the following falling edge.
module tb_iter_alu;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_MUL = 4'b0111;
   localparam logic [3:0] OP_BAD = 4'b0101;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   nBusy;

   iter_alu_if #(.XLEN(32)) busA ();
   iter_alu_if #(.XLEN(32)) busB ();

   iter_alu #(.XLEN(32), .EARLY_EXIT(1'b0)) dutFull (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (busA.slave)
   );

   iter_alu #(.XLEN(32), .EARLY_EXIT(1'b1)) dutEarly (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (busB.slave)
   );

   always #5 clk = ~clk;

   // Drives one issue slot on the selected instance and advances one cycle.
   task automatic applyStimulus(input bit early, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b);
      if (early) begin
         busB.start_i = 1'b1; busB.ALUCtrl_i = op; busB.data1_i = a; busB.data2_i = b;
      end else begin
         busA.start_i = 1'b1; busA.ALUCtrl_i = op; busA.data1_i = a; busA.data2_i = b;
      end
      @(negedge clk);
      busA.start_i = 1'b0;
      busB.start_i = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Counts busy cycles starting from the current one, bounded so a stuck DUT cannot hang the run.
   task automatic waitBusy(input bit early, output int n);
      n = 0;
      while ((early ? busB.busy_o : busA.busy_o) && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      busA.start_i = 1'b0; busA.ALUCtrl_i = OP_AND; busA.data1_i = '0; busA.data2_i = '0;
      busB.start_i = 1'b0; busB.ALUCtrl_i = OP_AND; busB.data1_i = '0; busB.data2_i = '0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_data", busA.data_o, 32'h0);
      checkOutput("reset_zero", {31'b0, busA.zero_o}, 32'h1);
      checkOutput("reset_busy", {31'b0, busA.busy_o}, 32'h0);
      checkOutput("reset_done", {31'b0, busA.done_o}, 32'h0);

      $display("[TB] logic ops");
      applyStimulus(1'b0, OP_AND, 32'hF0F01234, 32'h0FF0FFFF);
      checkOutput("and_done", {31'b0, busA.done_o}, 32'h1);
      checkOutput("and_data", busA.data_o, 32'h00F01234);
      checkOutput("and_zero", {31'b0, busA.zero_o}, 32'h0);
      @(negedge clk);
      checkOutput("and_done_drop", {31'b0, busA.done_o}, 32'h0);
      checkOutput("and_data_hold", busA.data_o, 32'h00F01234);
      applyStimulus(1'b0, OP_OR, 32'h00000001, 32'h80000000);
      checkOutput("or_data", busA.data_o, 32'h80000001);

      $display("[TB] arithmetic");
      applyStimulus(1'b0, OP_ADD, 32'hFFFFFFFF, 32'h00000001);
      checkOutput("add_wrap_data", busA.data_o, 32'h0);
      checkOutput("add_wrap_zero", {31'b0, busA.zero_o}, 32'h1);
      applyStimulus(1'b0, OP_SUB, 32'd5, 32'd7);
      checkOutput("sub_data", busA.data_o, 32'hFFFFFFFE);
      checkOutput("sub_zero", {31'b0, busA.zero_o}, 32'h0);
      applyStimulus(1'b0, OP_BAD, 32'h12345678, 32'h9ABCDEF0);
      checkOutput("bad_done", {31'b0, busA.done_o}, 32'h1);
      checkOutput("bad_data", busA.data_o, 32'h0);
      checkOutput("bad_zero", {31'b0, busA.zero_o}, 32'h1);
      @(negedge clk);

      $display("[TB] full-length multiply");
      applyStimulus(1'b0, OP_MUL, 32'd7, 32'hFFFFFFFD);
      waitBusy(1'b0, nBusy);
      checkOutput("mul_busy_cycles", nBusy, 32'd32);
      checkOutput("mul_done", {31'b0, busA.done_o}, 32'h1);
      checkOutput("mul_data", busA.data_o, 32'hFFFFFFEB);
      checkOutput("mul_zero", {31'b0, busA.zero_o}, 32'h0);
      @(negedge clk);

      $display("[TB] start ignored while busy");
      applyStimulus(1'b0, OP_MUL, 32'd7, 32'hFFFFFFFD);
      nBusy = 0;
      for (int i = 0; i < 5; i++) begin
         if (busA.busy_o) nBusy++;
         busA.start_i = 1'b1; busA.ALUCtrl_i = OP_ADD; busA.data1_i = 32'd1; busA.data2_i = 32'd1;
         @(negedge clk);
         busA.start_i = 1'b0;
      end
      while (busA.busy_o && nBusy < 200) begin
         nBusy++;
         @(negedge clk);
      end
      checkOutput("ign_busy_cycles", nBusy, 32'd32);
      checkOutput("ign_done", {31'b0, busA.done_o}, 32'h1);
      checkOutput("ign_data", busA.data_o, 32'hFFFFFFEB);
      @(negedge clk);
      checkOutput("ign_no_extra_done", {31'b0, busA.done_o}, 32'h0);
      checkOutput("ign_data_hold", busA.data_o, 32'hFFFFFFEB);

      $display("[TB] reset mid-multiply");
      applyStimulus(1'b0, OP_MUL, 32'd7, 32'hFFFFFFFD);
      repeat (10) @(negedge clk);
      checkOutput("rst_pre_busy", {31'b0, busA.busy_o}, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_busy", {31'b0, busA.busy_o}, 32'h0);
      checkOutput("rst_done", {31'b0, busA.done_o}, 32'h0);
      checkOutput("rst_data", busA.data_o, 32'h0);
      applyStimulus(1'b0, OP_ADD, 32'd2, 32'd3);
      checkOutput("post_rst_done", {31'b0, busA.done_o}, 32'h1);
      checkOutput("post_rst_add", busA.data_o, 32'd5);
      @(negedge clk);

      $display("[TB] early exit and back-to-back");
      applyStimulus(1'b1, OP_MUL, 32'd3, 32'd5);
      waitBusy(1'b1, nBusy);
      checkOutput("ee_busy_cycles", nBusy, 32'd3);
      checkOutput("ee_done", {31'b0, busB.done_o}, 32'h1);
      checkOutput("ee_data", busB.data_o, 32'd15);
      applyStimulus(1'b1, OP_ADD, 32'd10, 32'd20);
      checkOutput("b2b_done", {31'b0, busB.done_o}, 32'h1);
      checkOutput("b2b_data", busB.data_o, 32'd30);
      checkOutput("b2b_busy", {31'b0, busB.busy_o}, 32'h0);
      @(negedge clk);
      applyStimulus(1'b1, OP_MUL, 32'd9, 32'd0);
      waitBusy(1'b1, nBusy);
      checkOutput("ee_zero_busy_cycles", nBusy, 32'd1);
      checkOutput("ee_zero_data", busB.data_o, 32'd0);
      checkOutput("ee_zero_zero", {31'b0, busB.zero_o}, 32'h1);
      @(negedge clk);
      applyStimulus(1'b1, OP_MUL, 32'h00010001, 32'h80000000);
      waitBusy(1'b1, nBusy);
      checkOutput("ee_top_busy_cycles", nBusy, 32'd32);
      checkOutput("ee_top_data", busB.data_o, 32'h80000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
